// File: rtl/rect_fill_ctrl.sv
// Filled-rectangle controller: walks the rows of a rectangle from top to bottom,
// hands each horizontal span to an external line engine and forwards its pixels.
module rect_fill_ctrl #(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    busy,
    output logic                    valid,
    output logic                    done,
    output logic                    ln_start,
    output logic                    ln_oe,
    output logic signed [CORDW-1:0] ln_x0,
    output logic signed [CORDW-1:0] ln_x1,
    input  logic signed [CORDW-1:0] ln_x,
    input  logic                    ln_valid,
    input  logic                    ln_done
);

    typedef enum logic [1:0] {IDLE, LINE_START, LINE_WAIT, FINISH} state_t;

    localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

    function automatic logic signed [CORDW-1:0] smin(input logic signed [CORDW-1:0] a,
                                                     input logic signed [CORDW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [CORDW-1:0] smax(input logic signed [CORDW-1:0] a,
                                                     input logic signed [CORDW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t                  state_q, state_d;
    logic signed [CORDW-1:0] xa_q, xa_d;
    logic signed [CORDW-1:0] xb_q, xb_d;
    logic signed [CORDW-1:0] yb_q, yb_d;
    logic signed [CORDW-1:0] y_q, y_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ln_start_q, ln_start_d;

    always_comb begin
        state_d    = state_q;
        xa_d       = xa_q;
        xb_d       = xb_q;
        yb_d       = yb_q;
        y_d        = y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ln_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xa_d       = smin(x0, x1);
                    xb_d       = smax(x0, x1);
                    y_d        = smin(y0, y1);
                    yb_d       = smax(y0, y1);
                    busy_d     = 1'b1;
                    ln_start_d = 1'b1;
                    state_d    = LINE_START;
                end
            end
            LINE_START: begin
                state_d = LINE_WAIT;
            end
            LINE_WAIT: begin
                // ln_done is a one-cycle pulse, so it is taken regardless of oe
                if (ln_done) begin
                    if (y_q == yb_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        y_d        = y_q + ONE;
                        ln_start_d = 1'b1;
                        state_d    = LINE_START;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        xa_q <= xa_d;
        xb_q <= xb_d;
        yb_q <= yb_d;
        y_q  <= y_d;
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ln_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ln_start_q <= ln_start_d;
        end
    end

    // Pixel stream is a pass-through from the line engine while a span is running
    assign valid    = (state_q == LINE_WAIT) && ln_valid && !rst;
    assign ln_oe    = (state_q == LINE_WAIT) && oe && !rst;
    assign x        = (state_q == LINE_WAIT) ? ln_x : xa_q;
    assign y        = y_q;
    assign ln_x0    = xa_q;
    assign ln_x1    = xb_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ln_start = ln_start_q;

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Bench for rect_fill_ctrl: includes a simple horizontal-line engine model and
// directed rectangle scenarios with hand-computed pixel sequences.
module tb_rect_fill_ctrl;

    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rst, start, oe;
    logic signed [CW-1:0] x0, y0, x1, y1;
    logic signed [CW-1:0] x, y;
    logic                 busy, valid, done, ln_start, ln_oe;
    logic signed [CW-1:0] ln_x0, ln_x1, ln_x;
    logic                 ln_valid, ln_done;

    int checks = 0;
    int errors = 0;

    rect_fill_ctrl #(.CORDW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .oe(oe),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .x(x), .y(y), .busy(busy), .valid(valid), .done(done),
        .ln_start(ln_start), .ln_oe(ln_oe), .ln_x0(ln_x0), .ln_x1(ln_x1),
        .ln_x(ln_x), .ln_valid(ln_valid), .ln_done(ln_done)
    );

    always #5 clk = ~clk;

    // Horizontal-line engine: one pixel per enabled cycle, done pulse after the last
    logic                 eng_busy = 1'b0;
    logic                 eng_done = 1'b0;
    logic signed [CW-1:0] eng_x, eng_x1;

    always @(posedge clk) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_done <= 1'b0;
        end else begin
            eng_done <= 1'b0;
            if (ln_start) begin
                eng_x    <= ln_x0;
                eng_x1   <= ln_x1;
                eng_busy <= 1'b1;
            end else if (eng_busy && ln_oe) begin
                if (eng_x == eng_x1) begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                end else begin
                    eng_x <= eng_x + CW'(1);
                end
            end
        end
    end

    assign ln_x     = eng_x;
    assign ln_valid = eng_busy && ln_oe;
    assign ln_done  = eng_done;

    // Monitor: records every valid pixel and done pulse with its cycle number
    int                   cyc = 0;
    logic signed [CW-1:0] px_q[$];
    logic signed [CW-1:0] py_q[$];
    int                   pc_q[$];
    int                   done_cnt = 0;
    int                   done_cyc = 0;
    int                   last_lndone_cyc = 0;
    logic                 done_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            px_q.push_back(x);
            py_q.push_back(y);
            pc_q.push_back(cyc);
        end
        if (ln_done) last_lndone_cyc <= cyc;
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_busy <= busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_rect(input int ax0, input int ay0, input int ax1, input int ay1);
        x0    = CW'(ax0);
        y0    = CW'(ay0);
        x1    = CW'(ax1);
        y1    = CW'(ay1);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; oe = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (ln_start !== 1'b0) begin errors++; $display("FAIL reset_ln_start: got %b want 0", ln_start); end
        checks++; if (ln_oe !== 1'b0) begin errors++; $display("FAIL reset_ln_oe: got %b want 0", ln_oe); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int ex[6] = '{2, 3, 4, 2, 3, 4};
        int ey[6] = '{3, 3, 3, 4, 4, 4};
        int base = px_q.size();
        int d0 = done_cnt;
        bit ok;
        oe = 1'b1;
        start_rect(2, 3, 4, 4);
        wait_done(d0, 60, ok);
        tick(); tick();
        checks++; if (!ok) begin errors++; $display("FAIL normal_timeout: done not seen within 60 cycles"); end
        checks++; if (px_q.size() - base != 6) begin errors++; $display("FAIL normal_count: got %0d want 6", px_q.size() - base); end
        if (px_q.size() - base == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (px_q[base+i] !== CW'(ex[i]) || py_q[base+i] !== CW'(ey[i])) begin
                    errors++;
                    $display("FAIL normal_pix%0d: got (%0d,%0d) want (%0d,%0d)", i, px_q[base+i], py_q[base+i], ex[i], ey[i]);
                end
            end
            checks++; if (pc_q[base+2] - pc_q[base] != 2) begin errors++; $display("FAIL normal_row_contig: span %0d cycles want 2", pc_q[base+2] - pc_q[base]); end
            checks++; if (pc_q[base+3] - pc_q[base+2] != 3) begin errors++; $display("FAIL normal_row_gap: distance %0d want 3", pc_q[base+3] - pc_q[base+2]); end
        end
        checks++; if (done_cyc - last_lndone_cyc != 1) begin errors++; $display("FAIL normal_done_lat: got %0d want 1", done_cyc - last_lndone_cyc); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL normal_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_swapped();
        int base = px_q.size();
        int d0 = done_cnt;
        int nerr = 0;
        bit ok;
        oe = 1'b1;
        start_rect(5, 7, -1, 6);
        wait_done(d0, 100, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL swapped_timeout: done not seen within 100 cycles"); end
        checks++; if (px_q.size() - base != 14) begin errors++; $display("FAIL swapped_count: got %0d want 14", px_q.size() - base); end
        if (px_q.size() - base == 14) begin
            checks++;
            if (px_q[base] !== CW'(-1) || py_q[base] !== CW'(6)) begin
                errors++; $display("FAIL swapped_first: got (%0d,%0d) want (-1,6)", px_q[base], py_q[base]);
            end
            checks++;
            if (px_q[base+13] !== CW'(5) || py_q[base+13] !== CW'(7)) begin
                errors++; $display("FAIL swapped_last: got (%0d,%0d) want (5,7)", px_q[base+13], py_q[base+13]);
            end
            for (int i = 0; i < 14; i++) begin
                if (px_q[base+i] !== CW'(-1 + i % 7) || py_q[base+i] !== CW'(6 + i / 7)) nerr++;
            end
            checks++; if (nerr != 0) begin errors++; $display("FAIL swapped_order: %0d out-of-order pixels want 0", nerr); end
        end
    endtask

    task automatic test_single();
        int base = px_q.size();
        int d0 = done_cnt;
        bit ok;
        oe = 1'b1;
        start_rect(0, 0, 0, 0);
        wait_done(d0, 30, ok);
        tick(); tick();
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: done not seen within 30 cycles"); end
        checks++; if (px_q.size() - base != 1) begin errors++; $display("FAIL single_count: got %0d want 1", px_q.size() - base); end
        if (px_q.size() - base == 1) begin
            checks++;
            if (px_q[base] !== CW'(0) || py_q[base] !== CW'(0)) begin
                errors++; $display("FAIL single_pix: got (%0d,%0d) want (0,0)", px_q[base], py_q[base]);
            end
        end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", done_busy); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        logic [3:0]           pat = 4'b1001;
        int                   base = px_q.size();
        int                   d0 = done_cnt;
        int                   nerr = 0;
        bit                   fin = 1'b0;
        logic signed [CW-1:0] px_prev = '0, py_prev = '0;
        logic                 poe = 1'b1, pbusy = 1'b0, pdone = 1'b0, pstart = 1'b0;
        oe = 1'b1;
        start_rect(0, 0, 3, 1);
        for (int k = 0; k < 300 && !fin; k++) begin
            oe = pat[k[1:0]];
            @(negedge clk);
            if (!oe && !poe && busy && pbusy && !pdone && !pstart) begin
                checks++;
                if (x !== px_prev || y !== py_prev) begin
                    errors++;
                    $display("FAIL bp_hold: got (%0d,%0d) want held (%0d,%0d)", x, y, px_prev, py_prev);
                end
            end
            poe = oe; pbusy = busy; pdone = ln_done; pstart = ln_start;
            px_prev = x; py_prev = y;
            @(posedge clk);
            #1;
            if (done_cnt != d0) fin = 1'b1;
        end
        oe = 1'b1;
        tick();
        checks++; if (!fin) begin errors++; $display("FAIL bp_timeout: done not seen within 300 cycles"); end
        checks++; if (px_q.size() - base != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", px_q.size() - base); end
        if (px_q.size() - base == 8) begin
            for (int i = 0; i < 8; i++) begin
                if (px_q[base+i] !== CW'(i % 4) || py_q[base+i] !== CW'(i / 4)) nerr++;
            end
            checks++; if (nerr != 0) begin errors++; $display("FAIL bp_order: %0d wrong pixels want 0", nerr); end
        end
    endtask

    task automatic test_start_busy();
        int base = px_q.size();
        int d0 = done_cnt;
        int nerr = 0;
        bit ok;
        bit mid = 1'b0;
        oe = 1'b1;
        start_rect(0, 0, 2, 2);
        for (int i = 0; i < 60 && !mid; i++) begin
            tick();
            if (px_q.size() - base >= 4) mid = 1'b1;
        end
        checks++; if (!mid) begin errors++; $display("FAIL busy_mid_timeout: row 1 not reached within 60 cycles"); end
        x0 = CW'(5); y0 = CW'(5); x1 = CW'(9); y1 = CW'(9);
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        wait_done(d0, 80, ok);
        for (int i = 0; i < 6; i++) tick();
        checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: done not seen within 80 cycles"); end
        checks++; if (px_q.size() - base != 9) begin errors++; $display("FAIL busy_count: got %0d want 9", px_q.size() - base); end
        if (px_q.size() - base == 9) begin
            for (int i = 0; i < 9; i++) begin
                if (px_q[base+i] !== CW'(i % 3) || py_q[base+i] !== CW'(i / 3)) nerr++;
            end
            checks++; if (nerr != 0) begin errors++; $display("FAIL busy_order: %0d wrong pixels want 0", nerr); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int ex[4] = '{1, 2, 1, 2};
        int ey[4] = '{1, 1, 2, 2};
        int base = px_q.size();
        int d0 = done_cnt;
        int base2;
        bit ok;
        bit mid = 1'b0;
        oe = 1'b1;
        start_rect(0, 0, 3, 3);
        for (int i = 0; i < 60 && !mid; i++) begin
            tick();
            if (px_q.size() - base >= 6) mid = 1'b1;
        end
        checks++; if (!mid) begin errors++; $display("FAIL rstmid_timeout: row 1 not reached within 60 cycles"); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        checks++; if (ln_start !== 1'b0) begin errors++; $display("FAIL rstmid_ln_start: got %b want 0", ln_start); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); end
        base2 = px_q.size();
        start_rect(1, 1, 2, 2);
        wait_done(d0, 40, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_restart_timeout: done not seen within 40 cycles"); end
        checks++; if (px_q.size() - base2 != 4) begin errors++; $display("FAIL rstmid_restart_count: got %0d want 4", px_q.size() - base2); end
        if (px_q.size() - base2 == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (px_q[base2+i] !== CW'(ex[i]) || py_q[base2+i] !== CW'(ey[i])) begin
                    errors++;
                    $display("FAIL rstmid_pix%0d: got (%0d,%0d) want (%0d,%0d)", i, px_q[base2+i], py_q[base2+i], ex[i], ey[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_swapped();
        test_single();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
